// File: rtl/ipsmacge_pausch.sv
// ipsmacge_pausch - transmit-side 802.3x pause scheduler for the GE MAC.
// Merges per-source congestion levels into one XOFF/XON decision, requests
// pause frames from the pause generator, refreshes XOFF before the peer's
// quanta expires and optionally sends XON (quanta 0) on release.
// Optional build macro IPSMACGE_PAUSCH_STAT_EN adds the pcntclr input and the
// ocntxoff/ocntxon frame counters; without it the FSM behaves identically.
module ipsmacge_pausch #(
    parameter int NREQ    = 4,
    parameter int SLOTCLK = 64
) (
    input  logic            txclk,
    input  logic            txrst,
    input  logic            ppaudis,
    input  logic [15:0]     pcfgqnt,
    input  logic [15:0]     pcfgrfs,
    input  logic [NREQ-1:0] pcfgmsk,
    input  logic            pxonen,
    input  logic [NREQ-1:0] icongs,
    input  logic            paudone,
`ifdef IPSMACGE_PAUSCH_STAT_EN
    input  logic            pcntclr,
    output logic [15:0]     ocntxoff,
    output logic [15:0]     ocntxon,
`endif
    output logic            opaureq,
    output logic [15:0]     opauqnt,
    output logic            oxoff
);

    // Slot counter width; a single-cycle slot still needs one bit.
    localparam int SW = (SLOTCLK > 1) ? $clog2(SLOTCLK) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTCLK - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XOFF_REQ = 2'd1,
        ST_HOLD     = 2'd2,
        ST_XON_REQ  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_cong;
    logic [15:0]     r_qnt;
    logic [15:0]     w_qnt_next;
    logic            r_oxoff;
    logic            w_oxoff_next;
    logic [SW-1:0]   r_slot;
    logic [SW-1:0]   w_slot_next;
    logic [15:0]     r_refcnt;
    logic [15:0]     w_refcnt_next;
    logic [NREQ-1:0] w_src_act;
    logic            w_slot_wrap;
    logic [15:0]     w_rfs_eff;

    // Per-source active flags: a source only counts while its mask bit is set.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_src
            assign w_src_act[gi] = icongs[gi] & pcfgmsk[gi];
        end
    endgenerate

    assign w_slot_wrap = (r_slot == SLOT_LAST);
    // A refresh period of 0 slots would never fire; treat it as 1.
    assign w_rfs_eff   = (pcfgrfs == 16'd0) ? 16'd1 : pcfgrfs;

    // Register the merged congestion level once (gives the 2-clock request latency).
    always_ff @(posedge txclk or posedge txrst) begin
        if (txrst) begin
            r_cong <= 1'b0;
        end else begin
            r_cong <= |w_src_act;
        end
    end

    // FSM state, latched quanta, hold-off status and slot/refresh counters.
    always_ff @(posedge txclk or posedge txrst) begin
        if (txrst) begin
            r_state  <= ST_IDLE;
            r_qnt    <= 16'd0;
            r_oxoff  <= 1'b0;
            r_slot   <= '0;
            r_refcnt <= 16'd0;
        end else begin
            r_state  <= w_state_next;
            r_qnt    <= w_qnt_next;
            r_oxoff  <= w_oxoff_next;
            r_slot   <= w_slot_next;
            r_refcnt <= w_refcnt_next;
        end
    end

    // Next-state logic; quanta is only ever reloaded on entry into a *_REQ state.
    always_comb begin
        w_state_next  = r_state;
        w_qnt_next    = r_qnt;
        w_oxoff_next  = r_oxoff;
        w_slot_next   = r_slot;
        w_refcnt_next = r_refcnt;

        if (ppaudis) begin
            // Global disable overrides everything, including an owed frame.
            w_state_next  = ST_IDLE;
            w_oxoff_next  = 1'b0;
            w_slot_next   = '0;
            w_refcnt_next = 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_slot_next   = '0;
                    w_refcnt_next = 16'd0;
                    if (r_cong) begin
                        w_state_next = ST_XOFF_REQ;
                        w_qnt_next   = pcfgqnt;
                    end
                end

                ST_XOFF_REQ: begin
                    // An XOFF once requested is always sent, even if congestion clears.
                    if (paudone) begin
                        w_state_next  = ST_HOLD;
                        w_oxoff_next  = 1'b1;
                        w_refcnt_next = w_rfs_eff;
                        w_slot_next   = '0;
                    end
                end

                ST_HOLD: begin
                    if (!r_cong) begin
                        // Release takes priority over a refresh due this cycle.
                        w_slot_next   = '0;
                        w_refcnt_next = 16'd0;
                        if (pxonen) begin
                            w_state_next = ST_XON_REQ;
                            w_qnt_next   = 16'd0;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_oxoff_next = 1'b0;
                        end
                    end else if (w_slot_wrap) begin
                        w_slot_next = '0;
                        if (r_refcnt <= 16'd1) begin
                            // Refresh: resend XOFF before the peer's quanta runs out.
                            w_state_next  = ST_XOFF_REQ;
                            w_qnt_next    = pcfgqnt;
                            w_refcnt_next = 16'd0;
                        end else begin
                            w_refcnt_next = r_refcnt - 16'd1;
                        end
                    end else begin
                        w_slot_next = r_slot + 1'b1;
                    end
                end

                ST_XON_REQ: begin
                    // A completed XON wins over congestion returning in the same cycle;
                    // IDLE then re-requests XOFF on the following clock.
                    if (paudone) begin
                        w_state_next = ST_IDLE;
                        w_oxoff_next = 1'b0;
                    end else if (r_cong) begin
                        w_state_next = ST_XOFF_REQ;
                        w_qnt_next   = pcfgqnt;
                    end
                end

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign opaureq = (r_state == ST_XOFF_REQ) || (r_state == ST_XON_REQ);
    assign opauqnt = r_qnt;
    assign oxoff   = r_oxoff;

`ifdef IPSMACGE_PAUSCH_STAT_EN
    logic        w_xoff_done;
    logic        w_xon_done;
    logic [15:0] r_cntxoff;
    logic [15:0] r_cntxon;

    // A frame counts only when the FSM actually accepts its completion.
    assign w_xoff_done = !ppaudis && paudone && (r_state == ST_XOFF_REQ);
    assign w_xon_done  = !ppaudis && paudone && (r_state == ST_XON_REQ);

    // Sent-frame counters; clear beats increment, natural 16-bit wrap.
    always_ff @(posedge txclk or posedge txrst) begin
        if (txrst) begin
            r_cntxoff <= 16'd0;
            r_cntxon  <= 16'd0;
        end else if (pcntclr) begin
            r_cntxoff <= 16'd0;
            r_cntxon  <= 16'd0;
        end else begin
            if (w_xoff_done) begin
                r_cntxoff <= r_cntxoff + 16'd1;
            end
            if (w_xon_done) begin
                r_cntxon <= r_cntxon + 16'd1;
            end
        end
    end

    assign ocntxoff = r_cntxoff;
    assign ocntxon  = r_cntxon;
`endif

endmodule

// File: tb/tb_ipsmacge_pausch.sv
// Testbench for ipsmacge_pausch: directed scenarios followed by randomized
// congestion/config episodes checked against a timing model of the scheduler.
module tb_ipsmacge_pausch;

    localparam int NREQ    = 4;
    localparam int SLOTCLK = 64;

    logic            txclk = 1'b0;
    logic            txrst;
    logic            ppaudis;
    logic [15:0]     pcfgqnt;
    logic [15:0]     pcfgrfs;
    logic [NREQ-1:0] pcfgmsk;
    logic            pxonen;
    logic [NREQ-1:0] icongs;
    logic            paudone;
    logic            opaureq;
    logic [15:0]     opauqnt;
    logic            oxoff;
`ifdef IPSMACGE_PAUSCH_STAT_EN
    logic            pcntclr;
    logic [15:0]     ocntxoff;
    logic [15:0]     ocntxon;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ipsmacge_pausch #(.NREQ(NREQ), .SLOTCLK(SLOTCLK)) dut (
        .txclk   (txclk),
        .txrst   (txrst),
        .ppaudis (ppaudis),
        .pcfgqnt (pcfgqnt),
        .pcfgrfs (pcfgrfs),
        .pcfgmsk (pcfgmsk),
        .pxonen  (pxonen),
        .icongs  (icongs),
        .paudone (paudone),
`ifdef IPSMACGE_PAUSCH_STAT_EN
        .pcntclr (pcntclr),
        .ocntxoff(ocntxoff),
        .ocntxon (ocntxon),
`endif
        .opaureq (opaureq),
        .opauqnt (opauqnt),
        .oxoff   (oxoff)
    );

    always #5 txclk = ~txclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic pulse_done();
        paudone = 1'b1;
        tick();
        paudone = 1'b0;
    endtask

    // Count clocks until a request appears; budget expiry yields a mismatch.
    task automatic wait_req(input string tag, input int exp_cycles);
        int c;
        c = 0;
        while (!opaureq && c < 400) begin
            tick();
            c++;
        end
        check(tag, c, exp_cycles);
    endtask

    initial begin
        logic [15:0]     r_qnt;
        logic [15:0]     r_qnt2;
        logic [15:0]     r_rfs;
        logic [NREQ-1:0] r_msk;
        logic [NREQ-1:0] r_ic;
        logic            r_xon;
        logic            exp_cong;
        logic            any_req;
        int              exp_period;

        txrst   = 1'b1;
        ppaudis = 1'b0;
        pcfgqnt = 16'hFFFF;
        pcfgrfs = 16'd3;
        pcfgmsk = 4'hF;
        pxonen  = 1'b1;
        icongs  = 4'h0;
        paudone = 1'b0;
`ifdef IPSMACGE_PAUSCH_STAT_EN
        pcntclr = 1'b0;
`endif
        tick();
        tick();
        check("rst_req", opaureq, 0);
        check("rst_qnt", opauqnt, 0);
        check("rst_oxoff", oxoff, 0);
`ifdef IPSMACGE_PAUSCH_STAT_EN
        check("rst_cntxoff", ocntxoff, 0);
        check("rst_cntxon", ocntxon, 0);
`endif
        txrst = 1'b0;
        tick();

        // 1: congestion on one source -> request two clocks later
        icongs = 4'b0001;
        tick();
        check("t1_req_n1", opaureq, 0);
        tick();
        check("t1_req_n2", opaureq, 1);
        check("t1_qnt", opauqnt, 16'hFFFF);
        check("t1_oxoff_pre", oxoff, 0);
        pulse_done();
        check("t1_req_drop", opaureq, 0);
        check("t1_oxoff", oxoff, 1);
        check("t1_qnt_stable", opauqnt, 16'hFFFF);

        // 2: refresh after 3 slots of 64 clocks, quanta relatched
        pcfgqnt = 16'h1234;
        wait_req("t2_refresh_clks", 3 * SLOTCLK);
        check("t2_qnt", opauqnt, 16'h1234);
        check("t2_oxoff", oxoff, 1);
        pulse_done();
        check("t2_req_drop", opaureq, 0);

        // paudone while holding is ignored
        pulse_done();
        check("hold_done_req", opaureq, 0);
        check("hold_done_oxoff", oxoff, 1);

        // 3a: release with XON enabled
        icongs = 4'b0000;
        tick();
        tick();
        check("t3_xon_req", opaureq, 1);
        check("t3_xon_qnt", opauqnt, 0);
        check("t3_xon_oxoff", oxoff, 1);
        pulse_done();
        check("t3_xon_done_req", opaureq, 0);
        check("t3_xon_done_oxoff", oxoff, 0);
        tick();
        tick();
        check("t3_idle_req", opaureq, 0);

        // 3b: release with XON disabled
        pxonen = 1'b0;
        pcfgqnt = 16'h0200;
        icongs = 4'b0100;
        tick();
        tick();
        check("t3b_req", opaureq, 1);
        check("t3b_qnt", opauqnt, 16'h0200);
        pulse_done();
        icongs = 4'b0000;
        tick();
        check("t3b_oxoff_hold", oxoff, 1);
        tick();
        check("t3b_oxoff_rel", oxoff, 0);
        check("t3b_noreq", opaureq, 0);

        // 4: congestion returns while XON is pending
        pxonen = 1'b1;
        icongs = 4'b0010;
        tick();
        tick();
        pulse_done();
        icongs = 4'b0000;
        tick();
        tick();
        check("t4_xon_qnt", opauqnt, 0);
        pcfgqnt = 16'hABCD;
        icongs = 4'b0010;
        tick();
        check("t4_still_xon", opauqnt, 0);
        tick();
        check("t4_req", opaureq, 1);
        check("t4_qnt", opauqnt, 16'hABCD);
        pulse_done();
        check("t4_oxoff", oxoff, 1);

        // simultaneous XON completion and returning congestion
        icongs = 4'b0000;
        tick();
        tick();
        check("sim_xon_req", opaureq, 1);
        icongs = 4'b1000;
        tick();
        paudone = 1'b1;
        tick();
        paudone = 1'b0;
        check("sim_idle_req", opaureq, 0);
        check("sim_idle_oxoff", oxoff, 0);
        tick();
        check("sim_xoff_req", opaureq, 1);
        check("sim_xoff_qnt", opauqnt, 16'hABCD);
        pulse_done();

        // 5: masked sources never request
        pxonen = 1'b0;
        icongs = 4'b0000;
        tick();
        tick();
        tick();
        pcfgmsk = 4'b0000;
        icongs = 4'b1111;
        any_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_req = any_req | opaureq;
        end
        check("t5_masked", any_req, 0);
        pcfgmsk = 4'b1111;
        tick();
        tick();
        check("t5_unmask_req", opaureq, 1);
        ppaudis = 1'b1;
        tick();
        check("t5_dis_req", opaureq, 0);
        check("t5_dis_oxoff", oxoff, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_dis_held", opaureq, 0);
        ppaudis = 1'b0;
        tick();
        check("t5_resume_req", opaureq, 1);
        pulse_done();
        check("t5_resume_oxoff", oxoff, 1);

        // asynchronous reset while XON is requested
        pxonen = 1'b1;
        icongs = 4'b0000;
        tick();
        tick();
        check("arst_pre_req", opaureq, 1);
        #2 txrst = 1'b1;
        #1;
        check("arst_req", opaureq, 0);
        check("arst_oxoff", oxoff, 0);
        check("arst_qnt", opauqnt, 0);
        txrst = 1'b0;
        tick();
        tick();
        tick();
        check("arst_no_owed", opaureq, 0);

        // randomized episodes
        for (int it = 0; it < 20; it++) begin
            r_msk = 4'($urandom_range(0, 15));
            r_ic  = 4'($urandom_range(1, 15));
            r_qnt = 16'($urandom);
            r_qnt2 = 16'($urandom);
            r_rfs = 16'($urandom_range(0, 4));
            r_xon = 1'($urandom_range(0, 1));
            exp_cong = |(r_ic & r_msk);
            exp_period = ((r_rfs == 16'd0) ? 1 : int'(r_rfs)) * SLOTCLK;
            pcfgmsk = r_msk;
            pcfgqnt = r_qnt;
            pcfgrfs = r_rfs;
            pxonen  = r_xon;
            icongs  = r_ic;
            tick();
            tick();
            check($sformatf("rnd%0d_req", it), opaureq, exp_cong);
            if (exp_cong) begin
                check($sformatf("rnd%0d_qnt", it), opauqnt, r_qnt);
                pulse_done();
                check($sformatf("rnd%0d_oxoff", it), oxoff, 1);
                pcfgqnt = r_qnt2;
                wait_req($sformatf("rnd%0d_refresh", it), exp_period);
                check($sformatf("rnd%0d_qnt2", it), opauqnt, r_qnt2);
                pulse_done();
                icongs = 4'b0000;
                tick();
                tick();
                check($sformatf("rnd%0d_rel_req", it), opaureq, r_xon);
                check($sformatf("rnd%0d_rel_oxoff", it), oxoff, r_xon);
                if (r_xon) begin
                    check($sformatf("rnd%0d_xon_qnt", it), opauqnt, 0);
                    pulse_done();
                    check($sformatf("rnd%0d_xon_oxoff", it), oxoff, 0);
                end
            end else begin
                check($sformatf("rnd%0d_oxoff", it), oxoff, 0);
                icongs = 4'b0000;
            end
            tick();
            tick();
            tick();
        end

`ifdef IPSMACGE_PAUSCH_STAT_EN
        // 6: frame counters
        pcfgmsk = 4'hF;
        pcfgrfs = 16'd1;
        pcfgqnt = 16'h0005;
        pxonen  = 1'b1;
        pcntclr = 1'b1;
        tick();
        pcntclr = 1'b0;
        check("t6_clr_xoff", ocntxoff, 0);
        check("t6_clr_xon", ocntxon, 0);
        icongs = 4'b0001;
        tick();
        tick();
        pulse_done();
        wait_req("t6_ref1", SLOTCLK);
        pulse_done();
        wait_req("t6_ref2", SLOTCLK);
        pulse_done();
        icongs = 4'b0000;
        tick();
        tick();
        pulse_done();
        check("t6_cntxoff", ocntxoff, 3);
        check("t6_cntxon", ocntxon, 1);
        icongs = 4'b0001;
        tick();
        tick();
        paudone = 1'b1;
        pcntclr = 1'b1;
        tick();
        paudone = 1'b0;
        pcntclr = 1'b0;
        check("t6_clrwin_xoff", ocntxoff, 0);
        check("t6_clrwin_xon", ocntxon, 0);
        check("t6_oxoff", oxoff, 1);
        icongs = 4'b0000;
        tick();
        tick();
        pulse_done();
        check("t6_final_xon", ocntxon, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
